// File: rtl/axis_data_generator.sv
// Synthetic AXI4-Stream packet source: fixed-length packets at a programmable start-to-start period.
// Define AXIS_DATA_GEN_PKT_COUNT_EN to add the sent_pkt_count output.
module axis_data_generator #(
    parameter int G_AXIS_DATA_WIDTH = 1024
) (
    input  logic                           axis_streaming_data_clk,
    input  logic                           axis_streaming_rst,
    input  logic                           axis_data_gen_enable,
    input  logic [15:0]                    pkt_length,
    input  logic [15:0]                    period,
    output logic [G_AXIS_DATA_WIDTH-1:0]   axis_streaming_data_tx_tdata,
    output logic                           axis_streaming_data_tx_tvalid,
    output logic                           axis_streaming_data_tx_tuser,
    output logic [G_AXIS_DATA_WIDTH/8-1:0] axis_streaming_data_tx_tkeep,
    output logic                           axis_streaming_data_tx_tlast,
    input  logic                           axis_streaming_data_tx_tready
`ifdef AXIS_DATA_GEN_PKT_COUNT_EN
    ,
    output logic [31:0]                    sent_pkt_count
`endif
);

    localparam int LANES = G_AXIS_DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                        state_reg, state_next;
    logic [15:0]                   beat_reg, beat_next;
    logic [15:0]                   cnt_reg, cnt_next;
    logic [15:0]                   pkt_num_reg, pkt_num_next;
    logic [15:0]                   len_reg, len_next;
    logic [15:0]                   per_reg, per_next;
    logic                          tvalid_reg, tvalid_next;
    logic                          tlast_reg, tlast_next;
    logic [G_AXIS_DATA_WIDTH-1:0]  tdata_reg, tdata_next;

    logic        load_beat0;
    logic        pkt_done;
    logic        accept;
    logic        period_reached;
    logic [15:0] cnt_inc;

    always_comb begin
        state_next   = state_reg;
        beat_next    = beat_reg;
        cnt_next     = cnt_reg;
        pkt_num_next = pkt_num_reg;
        len_next     = len_reg;
        per_next     = per_reg;
        tvalid_next  = tvalid_reg;
        tlast_next   = tlast_reg;
        load_beat0   = 1'b0;
        pkt_done     = 1'b0;
        accept       = tvalid_reg && axis_streaming_data_tx_tready;
        cnt_inc      = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
        // 17-bit compare so that period 0 and period 1 both mean "already due"
        period_reached = ({1'b0, cnt_reg} + 17'd1) >= {1'b0, per_reg};

        case (state_reg)
            S_IDLE: begin
                if (axis_data_gen_enable) begin
                    state_next = S_SEND;
                    beat_next  = '0;
                    cnt_next   = '0;
                end
            end
            S_SEND: begin
                if (!tvalid_reg) begin
                    // first cycle after leaving IDLE: present beat 0
                    load_beat0 = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                    if (accept) begin
                        if (tlast_reg) begin
                            pkt_done     = 1'b1;
                            pkt_num_next = pkt_num_reg + 16'd1;
                            if (axis_data_gen_enable && period_reached) begin
                                load_beat0 = 1'b1;
                            end else begin
                                tvalid_next = 1'b0;
                                tlast_next  = 1'b0;
                                state_next  = axis_data_gen_enable ? S_GAP : S_IDLE;
                            end
                        end else begin
                            beat_next  = beat_reg + 16'd1;
                            tlast_next = (beat_reg + 16'd2 == len_reg);
                        end
                    end
                end
            end
            S_GAP: begin
                cnt_next = cnt_inc;
                if (!axis_data_gen_enable) begin
                    state_next = S_IDLE;
                end else if (period_reached) begin
                    state_next = S_SEND;
                    load_beat0 = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // packet start: sample the configuration and present beat 0
        if (load_beat0) begin
            beat_next   = '0;
            cnt_next    = '0;
            len_next    = (pkt_length == 16'd0) ? 16'd1 : pkt_length;
            per_next    = period;
            tvalid_next = 1'b1;
            tlast_next  = (len_next == 16'd1);
        end
    end

    // each 32-bit lane carries {packet number, beat index}; held otherwise
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign tdata_next[gi*32 +: 32] = tvalid_next ? {pkt_num_next, beat_next}
                                                         : tdata_reg[gi*32 +: 32];
        end
    endgenerate

    always_ff @(posedge axis_streaming_data_clk or posedge axis_streaming_rst) begin
        if (axis_streaming_rst) begin
            state_reg   <= S_IDLE;
            beat_reg    <= '0;
            cnt_reg     <= '0;
            pkt_num_reg <= '0;
            len_reg     <= 16'd1;
            per_reg     <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
            tdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            beat_reg    <= beat_next;
            cnt_reg     <= cnt_next;
            pkt_num_reg <= pkt_num_next;
            len_reg     <= len_next;
            per_reg     <= per_next;
            tvalid_reg  <= tvalid_next;
            tlast_reg   <= tlast_next;
            tdata_reg   <= tdata_next;
        end
    end

`ifdef AXIS_DATA_GEN_PKT_COUNT_EN
    logic [31:0] pkt_count_reg;

    always_ff @(posedge axis_streaming_data_clk or posedge axis_streaming_rst) begin
        if (axis_streaming_rst) begin
            pkt_count_reg <= '0;
        end else if (pkt_done) begin
            pkt_count_reg <= pkt_count_reg + 32'd1;
        end
    end

    assign sent_pkt_count = pkt_count_reg;
`endif

    assign axis_streaming_data_tx_tdata  = tdata_reg;
    assign axis_streaming_data_tx_tvalid = tvalid_reg;
    assign axis_streaming_data_tx_tlast  = tlast_reg;
    assign axis_streaming_data_tx_tuser  = 1'b0;
    assign axis_streaming_data_tx_tkeep  = '1;

endmodule

// File: tb/tb_axis_data_generator.sv
// Bench for axis_data_generator: table of packet configurations plus enable-drop and
// mid-packet reset sequences; accepted beats are checked against a scoreboard queue.
module tb_axis_data_generator;

    localparam int W     = 1024;
    localparam int LANES = W / 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [15:0]    pkt_length;
    logic [15:0]    period;
    logic [W-1:0]   tdata;
    logic           tvalid;
    logic           tuser;
    logic [W/8-1:0] tkeep;
    logic           tlast;
    logic           tready;
`ifdef AXIS_DATA_GEN_PKT_COUNT_EN
    logic [31:0]    sent_pkt_count;
`endif

    always #5 clk = ~clk;

    axis_data_generator #(.G_AXIS_DATA_WIDTH(W)) dut (
        .axis_streaming_data_clk       (clk),
        .axis_streaming_rst            (rst),
        .axis_data_gen_enable          (en),
        .pkt_length                    (pkt_length),
        .period                        (period),
        .axis_streaming_data_tx_tdata  (tdata),
        .axis_streaming_data_tx_tvalid (tvalid),
        .axis_streaming_data_tx_tuser  (tuser),
        .axis_streaming_data_tx_tkeep  (tkeep),
        .axis_streaming_data_tx_tlast  (tlast),
        .axis_streaming_data_tx_tready (tready)
`ifdef AXIS_DATA_GEN_PKT_COUNT_EN
        ,
        .sent_pkt_count                (sent_pkt_count)
`endif
    );

    typedef struct {
        logic [15:0] p;
        logic [15:0] b;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] len;
        logic [15:0] per;
        bit          rmode;
        int          npkts;
        int          interval;
    } case_t;

    beat_t       sb_q[$];
    case_t       cases[7];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int          starts = 0;
    int          accepted = 0;
    int unsigned start_cyc[8];
    bit          ready_mode = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_last = 1'b0;
    logic [W-1:0] prev_data = '0;

    function automatic logic [W-1:0] exp_data(input logic [15:0] p, input logic [15:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*32 +: 32] = {p, b};
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkts(input int npkts, input logic [15:0] len);
        logic [15:0] eff;
        beat_t e;
        eff = (len == 16'd0) ? 16'd1 : len;
        for (int p = 0; p < npkts; p++) begin
            for (int b = 0; b < int'(eff); b++) begin
                e.p    = 16'(p);
                e.b    = 16'(b);
                e.last = (b == int'(eff) - 1);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        en  = 1'b0;
        rst = 1'b1;
        prev_valid = 1'b0;
        sb_q.delete();
        starts   = 0;
        accepted = 0;
        #1;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tdata", tdata, '0);
        check("rst_tuser", tuser, 1'b0);
        check("rst_tkeep", tkeep, {(W/8){1'b1}});
`ifdef AXIS_DATA_GEN_PKT_COUNT_EN
        check("rst_count", sent_pkt_count, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        for (int k = 0; k < budget && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats still expected", sb_q.size());
        end
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int k = 0; k < budget && starts < n; k++) begin
            @(negedge clk);
            #1;
        end
        if (starts < n) begin
            tests++;
            fails++;
            $display("FAIL start_timeout: saw %0d starts, needed %0d", starts, n);
        end
    endtask

    task automatic wait_accepted(input int n, input int budget);
        for (int k = 0; k < budget && accepted < n; k++) begin
            @(negedge clk);
            #1;
        end
        if (accepted < n) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: saw %0d beats, needed %0d", accepted, n);
        end
    endtask

    // Ready driver: constant high, or toggling every cycle
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            tready = ready_mode ? ~tready : 1'b1;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: stability under stall, packet start times, scoreboard compare
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", tvalid, 1'b1);
                check("hold_data", tdata, prev_data);
                check("hold_last", tlast, prev_last);
            end
            if (tvalid && (!prev_valid || (prev_ready && prev_last))) begin
                if (starts < 8) start_cyc[starts] = cyc;
                starts++;
            end
            if (tvalid && tready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got lane0 %0h, no beat expected", tdata[31:0]);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    check("beat_data", tdata, exp_data(e.p, e.b));
                    check("beat_last", tlast, e.last);
                end
                accepted++;
            end
            prev_valid = tvalid;
            prev_ready = tready;
            prev_last  = tlast;
            prev_data  = tdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        pkt_length = 16'd0;
        period     = 16'd0;

        //          len      per      rmode npkts interval
        cases[0] = '{16'd64, 16'd128, 1'b0, 3,    128};
        cases[1] = '{16'd4,  16'd0,   1'b0, 3,    4};
        cases[2] = '{16'd8,  16'd10,  1'b1, 3,    16};
        cases[3] = '{16'd0,  16'd3,   1'b0, 3,    3};
        cases[4] = '{16'd5,  16'd3,   1'b0, 3,    5};
        cases[5] = '{16'd1,  16'd1,   1'b0, 4,    1};
        cases[6] = '{16'd2,  16'd0,   1'b1, 3,    4};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            pkt_length = cases[i].len;
            period     = cases[i].per;
            ready_mode = cases[i].rmode;
            push_pkts(cases[i].npkts, cases[i].len);
            @(posedge clk);
            #2;
            en = 1'b1;
            @(posedge clk);
            #1;
            check("latency_pre", tvalid, 1'b0);
            @(posedge clk);
            #1;
            check("latency_beat0", tvalid, 1'b1);
            wait_starts(cases[i].npkts, 5000);
            en = 1'b0;
            wait_empty(3000);
            repeat (5) @(posedge clk);
            #1;
            check("idle_after", tvalid, 1'b0);
            check("interval", 32'(start_cyc[2] - start_cyc[1]), 32'(cases[i].interval));
`ifdef AXIS_DATA_GEN_PKT_COUNT_EN
            check("pkt_count", sent_pkt_count, 32'(cases[i].npkts));
`endif
            $display("[TB] case %0d len=%0d period=%0d toggle=%0d pkts=%0d interval=%0d",
                     i, cases[i].len, cases[i].per, cases[i].rmode, cases[i].npkts,
                     start_cyc[2] - start_cyc[1]);
        end
        ready_mode = 1'b0;

        // Enable dropped while beat 10 of a 64-beat packet is presented
        do_reset();
        pkt_length = 16'd64;
        period     = 16'd128;
        push_pkts(1, 16'd64);
        @(posedge clk);
        #2;
        en = 1'b1;
        wait_accepted(10, 500);
        en = 1'b0;
        wait_empty(500);
        repeat (140) @(posedge clk);
        #1;
        check("drop_idle", tvalid, 1'b0);
        check("drop_starts", 32'(starts), 32'd1);
        $display("[TB] enable drop at beat 10: %0d beats accepted", accepted);

        // Reset pulse while beat 20 is presented
        do_reset();
        pkt_length = 16'd64;
        period     = 16'd128;
        push_pkts(1, 16'd64);
        @(posedge clk);
        #2;
        en = 1'b1;
        wait_accepted(20, 500);
        #1;
        rst = 1'b1;
        prev_valid = 1'b0;
        #1;
        check("async_rst_tvalid", tvalid, 1'b0);
        check("async_rst_tlast", tlast, 1'b0);
        check("async_rst_tdata", tdata, '0);
        sb_q.delete();
        starts   = 0;
        accepted = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_pkts(1, 16'd64);
        wait_starts(1, 100);
        en = 1'b0;
        wait_empty(500);
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", tvalid, 1'b0);
`ifdef AXIS_DATA_GEN_PKT_COUNT_EN
        check("post_rst_count", sent_pkt_count, 32'd1);
`endif
        $display("[TB] reset at beat 20, restart: %0d beats accepted", accepted);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_data_generator.md
# axis_data_generator

Synthetic AXI4-Stream packet source feeding the 1024-bit streaming TX port of the 400G UDP/IP interface. When enabled, it emits fixed-length packets, each `pkt_length` beats long, at a programmable start-to-start interval of `period` clock cycles. The payload is a deterministic counter pattern so a downstream checker can verify it. It is used as bring-up and throughput stimulus in front of the UDP/IP TX path.

## Interface
- `G_AXIS_DATA_WIDTH`, default 1024: tdata width in bits; must be a multiple of 32. tkeep width is `G_AXIS_DATA_WIDTH/8`.
- `axis_streaming_data_clk`  in  1: the single clock; all logic is on its rising edge.
- `axis_streaming_rst`  in  1: asynchronous, active-high reset.
- `axis_data_gen_enable`  in  1: run enable, level sensitive.
- `pkt_length`  in  16: packet length in beats; 0 is treated as 1.
- `period`  in  16: start-to-start interval in cycles; 0 means back-to-back.
- `axis_streaming_data_tx_tdata`  out  G_AXIS_DATA_WIDTH: payload.
- `axis_streaming_data_tx_tvalid`  out  1: beat valid.
- `axis_streaming_data_tx_tuser`  out  1: error flag; always 0.
- `axis_streaming_data_tx_tkeep`  out  G_AXIS_DATA_WIDTH/8: always all ones.
- `axis_streaming_data_tx_tlast`  out  1: marks the last beat of a packet.
- `axis_streaming_data_tx_tready`  in  1: downstream ready.
- `sent_pkt_count`  out  32: number of packets completed; present only with `AXIS_DATA_GEN_PKT_COUNT_EN`.

## Operation
- FSM states: IDLE, SEND, GAP.
- **IDLE → SEND:** on the first edge where enable is sampled high. The beat index and the period counter both clear to 0.
- **SEND:** presents beats 0 to `pkt_length-1`. A beat advances only on `tvalid && tready`. tlast is high on beat `pkt_length-1` only.
- **Leaving SEND:** when the tlast beat is accepted:
  - go to SEND immediately (next packet, index 0) if enable is high and the period counter is ≥ `period-1`;
  - otherwise go to GAP if enable is high;
  - otherwise go to IDLE.
- **GAP:** tvalid is low. Go to SEND when the period counter reaches `period-1`. If enable drops during GAP, go to IDLE.
- **Period counter:** increments every cycle from the first-beat presentation and saturates at 0xFFFF. Backpressure or `pkt_length ≥ period` stretches the interval; there is never a negative gap.
- **Enable low during SEND:** the current packet completes; packets are never truncated.
- **Sampling:** `pkt_length` and `period` are sampled at packet start and held for that packet.
- **Payload:** every 32-bit lane of beat b of packet p carries `{p[15:0], b[15:0]}`. p starts at 0 after reset and wraps at 0xFFFF.
- **AXIS rules:** tdata, tlast, tkeep and tuser are stable while `tvalid && !tready`. Once tvalid is asserted, it is never deasserted before acceptance.

## Timing
- **Reset values:** tvalid=0, tlast=0, tdata=0, tuser=0, tkeep=all ones, state=IDLE, counters=0, `sent_pkt_count`=0.
- **Start latency:** all outputs are registered. If enable is sampled high at edge N, beat 0 is valid after edge N+1.
- **Throughput:** one beat per cycle when tready is high.
- **Reset mid-packet:** outputs return to reset values immediately (asynchronous), with no tlast emitted. The packet sequence number restarts at 0.

## Configuration
- **`AXIS_DATA_GEN_PKT_COUNT_EN` defined:** adds the `sent_pkt_count` output port. It increments on each accepted tlast beat, wraps at 2^32, and is cleared only by reset.
- **Not defined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Nominal:** `pkt_length`=64, `period`=128, tready=1, enable high → tvalid high 64 cycles, low 64 cycles, repeating. tlast on beat 63; packet 1 beat 5 lanes = 0x00010005.
- **Back-to-back:** `period`=0, `pkt_length`=4 → tvalid continuously high, tlast every 4th cycle, p increments each packet.
- **Backpressure:** tready toggles every cycle, `pkt_length`=8, `period`=10 → data held stable while stalled. The packet takes 16 cycles, so the next start is immediate (interval 16).
- **Enable drop:** enable deasserted at beat 10 of a 64-beat packet → beats 10..63 still sent with tlast, then IDLE with tvalid=0.
- **Reset mid-packet:** `axis_streaming_rst` pulses at beat 20 → tvalid=0 asynchronously. After release with enable high, the next packet starts at beat 0 with p=0.
- **Counter (macro on):** 3 packets completed → `sent_pkt_count`=3; reset → 0.
